data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  initiator request strobe.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 addr  input  32  byte address; addr[1:0] ignored.
REQ-008 be  input  4  byte enables for writes, be[i] selects wdata[8i+7:8i].
REQ-009 wdata  input  32  write data.
REQ-010 ready  output  1  responder can accept a request this cycle.
REQ-011 rvalid  output  1  one-cycle response pulse.
REQ-012 rdata  output  32  read data, valid only with rvalid.
REQ-013 err  output  1  out-of-range flag, valid only with rvalid.

Function
REQ-014 FSM states IDLE, WAIT, RESP; ready = 1 only in IDLE.
REQ-015 Acceptance: req=1 and ready=1 at a rising edge; addr, we, be, wdata captured in that edge; req while ready=0 ignored, no queuing.
REQ-016 IDLE -> WAIT on acceptance when LATENCY>1; IDLE -> RESP directly when LATENCY=1.
REQ-017 WAIT: down-counter loaded with LATENCY-1 at acceptance, decremented each cycle; WAIT -> RESP when counter reaches 1.
REQ-018 rvalid = 1 exactly LATENCY cycles after the acceptance edge, for exactly one cycle (state RESP); RESP -> IDLE unconditionally.
REQ-019 req asserted during RESP not accepted; earliest next acceptance is the cycle after rvalid (ready=1 again).
REQ-020 Word index = captured addr[log2(DEPTH_WORDS)+1:2]; in range iff captured addr < 4*DEPTH_WORDS.
REQ-021 In-range read: rdata = stored word at index during RESP, err=0.
REQ-022 In-range write: bytes with be[i]=1 updated at the edge ending RESP; other bytes unchanged; rdata=0, err=0.
REQ-023 Write with be=4'b0000: no storage change, response still issued, err=0.
REQ-024 Out-of-range access: no storage change, rdata=0, err=1 with rvalid.
REQ-025 rdata and err = 0 whenever rvalid=0.
REQ-026 Read issued after a completed write to the same index returns the merged new word.

Reset
REQ-027 reset=1 at an edge: state IDLE, counter 0, captured request cleared, ready=1 from the next cycle, rvalid=0, rdata=0, err=0.
REQ-028 reset clears every storage word to 32'h00000000.
REQ-029 reset during WAIT or RESP aborts the transaction: no write performed, no rvalid issued; reset has priority over acceptance.

Verification
REQ-030 LATENCY=2: write addr 0x10, be 4'hF, wdata 0xDEADBEEF at cycle t -> ready=0 at t+1, rvalid=1 at t+2, err=0, ready=1 at t+3; read 0x10 -> rdata 0xDEADBEEF two cycles after acceptance.
REQ-031 Partial write: word 0x20 = 0x11223344, write be 4'b0101 wdata 0xAABBCCDD -> subsequent read returns 0x11BB33DD.
REQ-032 Out of range: read addr 0x1000 (DEPTH 1024) -> rvalid with err=1, rdata=0; write 0x1000 then read 0x0 -> rdata unchanged.
REQ-033 Back-to-back: req held high continuously for two reads -> second accepted on the cycle after first rvalid; rvalid pulses exactly LATENCY+1 cycles apart.
REQ-034 Reset mid-operation: write 0x30 accepted, reset asserted one cycle later -> no rvalid, read 0x30 after reset returns 0x00000000.
REQ-035 LATENCY=1 build: read accepted at t -> rvalid at t+1, ready=1 at t+2.

Source files
------------

// File: rtl/data_mem_if.sv
// Request/response bus between an initiator and the data memory responder.
// The master drives the request fields; the slave returns ready and the response.
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with a fixed response latency, byte-enabled
// writes and an out-of-range error flag; storage is cleared by reset.
module data_mem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [32:0] LIMIT    = 33'(64'(DEPTH_WORDS) * 64'd4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             in_range;
  logic             mem_wr;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wr_word;

  assign accept   = bus.req && (state_q == S_IDLE);
  assign in_range = ({1'b0, addr_q} < LIMIT);
  assign idx      = addr_q[IDX_W+1:2];
  assign mem_wr   = (state_q == S_RESP) && we_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          be_d    = bus.be;
          wdata_d = bus.wdata;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Merge enabled bytes of the captured write data into the current word
  always_comb begin
    wr_word = mem_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset wins over a pending write, so an aborted transaction never lands
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_wr) begin
      mem_q[idx] <= wr_word;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.rvalid = (state_q == S_RESP);
  assign bus.rdata  = ((state_q == S_RESP) && !we_q && in_range) ? mem_q[idx] : '0;
  assign bus.err    = (state_q == S_RESP) && !in_range;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic on a
// LATENCY=2/DEPTH=1024 instance and a LATENCY=1/DEPTH=64 instance, against a word-array model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  logic [31:0] mdl [2][1024];
  logic [31:0] last_rdata;
  logic        last_err;

  data_mem_if bus2 ();
  data_mem_if bus1 ();

  data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(64)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic f_ready(input int s);
    return s != 0 ? bus1.ready : bus2.ready;
  endfunction
  function automatic logic f_rvalid(input int s);
    return s != 0 ? bus1.rvalid : bus2.rvalid;
  endfunction
  function automatic logic f_err(input int s);
    return s != 0 ? bus1.err : bus2.err;
  endfunction
  function automatic logic [31:0] f_rdata(input int s);
    return s != 0 ? bus1.rdata : bus2.rdata;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    if (s != 0) begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.be = b; bus1.wdata = d;
    end else begin
      bus2.req = r; bus2.we = w; bus2.addr = a; bus2.be = b; bus2.wdata = d;
    end
  endtask

  task automatic clear_models();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) mdl[s][i] = 32'h0;
  endtask

  task automatic check_idle(input int s, input string tag);
    chk({tag, "_ready"},  32'(f_ready(s)),  32'd1);
    chk({tag, "_rvalid"}, 32'(f_rvalid(s)), 32'd0);
    chk({tag, "_err"},    32'(f_err(s)),    32'd0);
    chk({tag, "_rdata"},  f_rdata(s),       32'h0);
  endtask

  // One complete transaction, checked for latency, handshake timing and response
  task automatic txn(input int s, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    int lat, dep, n;
    logic [31:0] idx, exp_d, merged;
    logic exp_e;
    lat   = (s != 0) ? 1 : 2;
    dep   = (s != 0) ? 64 : 1024;
    exp_e = ({1'b0, a} >= 33'(4 * dep));
    idx   = (a >> 2) & 32'(dep - 1);
    exp_d = (!w && !exp_e) ? mdl[s][idx] : 32'h0;
    drive(s, 1'b1, w, a, b, d);
    n = 0;
    while (!f_ready(s) && n < 50) begin step(); n++; end
    chk("ready_timeout", 32'(n < 50), 32'd1);
    step();
    drive(s, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    n = 1;
    while (!f_rvalid(s) && n < 20) begin
      chk("busy_ready", 32'(f_ready(s)), 32'd0);
      chk("idle_rdata", f_rdata(s), 32'h0);
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("resp_ready", 32'(f_ready(s)), 32'd0);
    chk("resp_err", 32'(f_err(s)), 32'(exp_e));
    chk("resp_rdata", f_rdata(s), exp_d);
    last_rdata = f_rdata(s);
    last_err   = f_err(s);
    if (w && !exp_e) begin
      merged = mdl[s][idx];
      for (int i = 0; i < 4; i++) if (b[i]) merged[8*i +: 8] = d[8*i +: 8];
      mdl[s][idx] = merged;
    end
    step();
    check_idle(s, "after_resp");
  endtask

  // Two reads with req held high: response pulses must be LATENCY+1 apart
  task automatic b2b(input int s);
    int t0, t1, k, n;
    t0 = 0; t1 = 0; k = 0; n = 0;
    drive(s, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    while (k < 2 && n < 30) begin
      step();
      n++;
      if (f_rvalid(s)) begin
        chk("b2b_rdata", f_rdata(s), mdl[s][4]);
        if (k == 0) t0 = cyc; else t1 = cyc;
        k++;
      end
    end
    drive(s, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("b2b_count", 32'(k), 32'd2);
    chk("b2b_spacing", 32'(t1 - t0), 32'((s != 0 ? 1 : 2) + 1));
    step();
    step();
    check_idle(s, "b2b_end");
  endtask

  initial begin
    int s, r, dep, gap;
    logic [31:0] a, d;
    logic [3:0] b;
    logic w;

    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    clear_models();
    step();
    step();
    reset = 1'b0;
    check_idle(0, "reset2");
    check_idle(1, "reset1");

    // Full write then read back on the LATENCY=2 instance
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    chk("wr_err", 32'(last_err), 32'd0);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("rd_deadbeef", last_rdata, 32'hDEADBEEF);

    // Partial write merge
    txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    txn(0, 1'b0, 32'h23, 4'h0, 32'h0);
    chk("partial_merge", last_rdata, 32'h11BB33DD);

    // Zero byte-enable write leaves the word unchanged
    txn(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'h20, 4'h0, 32'h0);
    chk("be_zero", last_rdata, 32'h11BB33DD);

    // Out-of-range boundary
    txn(0, 1'b0, 32'h1000, 4'h0, 32'h0);
    chk("oor_err", 32'(last_err), 32'd1);
    chk("oor_rdata", last_rdata, 32'h0);
    txn(0, 1'b1, 32'h0, 4'hF, 32'h5A5A0001);
    txn(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oor_no_write", last_rdata, 32'h5A5A0001);
    txn(0, 1'b1, 32'hFFF, 4'hF, 32'h0BADCAFE);
    txn(0, 1'b0, 32'hFFC, 4'h0, 32'h0);
    chk("top_word", last_rdata, 32'h0BADCAFE);
    chk("top_word_err", 32'(last_err), 32'd0);

    // Back-to-back requests on both instances
    b2b(0);
    txn(1, 1'b1, 32'h10, 4'hF, 32'h600DF00D);
    b2b(1);

    // LATENCY=1 instance: boundary of a 64-word memory
    txn(1, 1'b0, 32'h100, 4'h0, 32'h0);
    chk("l1_oor_err", 32'(last_err), 32'd1);
    txn(1, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("l1_read", last_rdata, 32'h600DF00D);

    // Reset one cycle after accepting a write aborts it
    txn(0, 1'b1, 32'h30, 4'hF, 32'h12345678);
    drive(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("abort_accepted", 32'(bus2.ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_models();
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_rvalid", 32'(bus2.rvalid), 32'd0);
      chk("abort_ready", 32'(bus2.ready), 32'd1);
      step();
    end
    txn(0, 1'b0, 32'h30, 4'h0, 32'h0);
    chk("abort_read", last_rdata, 32'h0);

    // Reset during the response cycle suppresses the write
    drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'hA5A5A5A5);
    step();
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    chk("resp_abort_rvalid", 32'(bus2.rvalid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_models();
    check_idle(0, "resp_abort");
    txn(0, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("resp_abort_read", last_rdata, 32'h0);

    // Randomized traffic on both instances
    for (int k = 0; k < 120; k++) begin
      s   = k % 2;
      dep = (s != 0) ? 64 : 1024;
      r   = int'($urandom_range(0, 9));
      if (r == 0)      a = $urandom | 32'h80000000;
      else if (r == 1) a = 32'(4 * dep) + 32'($urandom_range(0, 15));
      else if (r == 2) a = 32'(4 * dep - 4) + 32'($urandom_range(0, 3));
      else             a = 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      b   = 4'($urandom);
      d   = $urandom;
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
      txn(s, w, a, b, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
